// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  localparam int unsigned DW  = 8;
  localparam int unsigned D1W = DW + 1;
  localparam int unsigned CW  = $clog2(D1W);

  typedef logic [DW:0]   comp2_t;
  typedef logic [DW:0]   mag_t;
  typedef logic [DW+1:0] prem_t;
  typedef logic          signal_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FIX, DONE} div_state_t;

  typedef struct packed {
    comp2_t  quotient;
    comp2_t  remainder;
    signal_t div_by_zero;
    signal_t overflow;
  } div_res_t;

  // Unsigned magnitude of a two's-complement value; the most negative
  // value maps to 2^DW, which still fits in DW+1 unsigned bits.
  function automatic mag_t abs_mag(comp2_t x);
    return x[DW] ? mag_t'(-x) : mag_t'(x);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_restore_step
  import div_pkg::*;
(
  input  prem_t   part_rem,
  input  signal_t next_bit,
  input  mag_t    div_mag,
  output prem_t   part_rem_next,
  output signal_t q_bit
);

  prem_t shifted;
  prem_t trial;

  // Keep the trial difference when non-negative, otherwise restore.
  always_comb begin
    shifted       = (part_rem << 1) | prem_t'(next_bit);
    trial         = shifted - {1'b0, div_mag};
    q_bit         = ~trial[DW+1];
    part_rem_next = trial[DW+1] ? shifted : trial;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider with start/ready handshake.
module seq_divider
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW:0]   dividend,
  input  logic [DW:0]   divisor,
  output logic          ready,
  output logic          done,
  output logic [DW:0]   quotient,
  output logic [DW:0]   remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  div_state_t state, state_nxt;
  div_res_t   res;
  comp2_t     a_op, b_op;
  mag_t       amag, bmag;
  prem_t      prem, prem_nxt;
  cnt_t       cnt;
  signal_t    sign_q, sign_r, q_bit;
  mag_t       rem_mag;

  assign rem_mag = prem[DW:0];

  div_restore_step u_step (
    .part_rem      (prem),
    .next_bit      (amag[DW]),
    .div_mag       (bmag),
    .part_rem_next (prem_nxt),
    .q_bit         (q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = LOAD;
      end
      LOAD:    state_nxt = (b_op == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result registers.
  // The dividend magnitude register doubles as the quotient shift register:
  // dividend bits leave at the MSB while quotient bits enter at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res    <= '0;
      a_op   <= '0;
      b_op   <= '0;
      amag   <= '0;
      bmag   <= '0;
      prem   <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_op <= dividend;
            b_op <= divisor;
            res  <= '0;
          end
        end
        LOAD: begin
          if (b_op == '0) begin
            res.quotient    <= '0;
            res.remainder   <= a_op;
            res.div_by_zero <= 1'b1;
          end else begin
            amag   <= abs_mag(a_op);
            bmag   <= abs_mag(b_op);
            sign_q <= a_op[DW] ^ b_op[DW];
            sign_r <= a_op[DW];
            prem   <= '0;
            cnt    <= CW'(DW);
          end
        end
        SHIFT: begin
          prem <= prem_nxt;
          amag <= {amag[DW-1:0], q_bit};
          cnt  <= cnt - CW'(1);
        end
        FIX: begin
          if (!sign_q && amag[DW]) begin
            res.quotient  <= {1'b0, {DW{1'b1}}};
            res.remainder <= '0;
            res.overflow  <= 1'b1;
          end else begin
            res.quotient  <= sign_q ? comp2_t'(-amag) : comp2_t'(amag);
            res.remainder <= sign_r ? comp2_t'(-rem_mag) : comp2_t'(rem_mag);
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = res.quotient;
  assign remainder   = res.remainder;
  assign div_by_zero = res.div_by_zero;
  assign overflow    = res.overflow;

endmodule
